pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipe_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned STALL_W         = 16;
  localparam int unsigned INIT_CYCLES_DEF = 4;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu_hazard
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu_hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: post-reset drain, hazard prioritisation, memory-wait
// freeze with sticky timeout, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_jump,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               ex_branch_taken,
  input  logic               ex_jr,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               idex_write,
  output logic               exmem_write,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               redirect,
  output logic               init_done,
  output logic               mem_timeout,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int unsigned DRAIN_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               lu_block_q;
  logic               lu_hazard;
  logic               lu_take;
  logic               mem_wait;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .lu_hazard   (lu_hazard)
  );

  assign mem_wait = dmem_req & ~dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state and pipeline enables/flushes, highest-priority hazard first
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    if_flush    = 1'b1;
    id_flush    = 1'b1;
    ex_flush    = 1'b1;
    redirect    = 1'b0;
    lu_take     = 1'b0;
    case (state_q)
      INIT: begin
        if (drain_q == DRAIN_LAST) state_d = RUN;
      end
      RUN, MEM_WAIT: begin
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else begin
          state_d     = RUN;
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          if (ex_branch_taken || ex_jr) begin
            redirect = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (lu_hazard && !lu_block_q) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            id_flush   = 1'b1;
            lu_take    = 1'b1;
          end else if (id_jump) begin
            if_flush = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Drain counter and init_done; the count restarts on every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q   <= '0;
      init_done <= 1'b0;
    end else begin
      if (state_q == INIT && state_d == INIT) drain_q <= drain_q + DRAIN_W'(1);
      if (state_d != INIT) init_done <= 1'b1;
    end
  end

  // Memory-wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (state_q != MEM_WAIT && state_d == MEM_WAIT) wait_q <= '0;
      else if (state_q == MEM_WAIT && wait_q != WAIT_MAX) wait_q <= wait_q + WAIT_W'(1);
      if (state_q == MEM_WAIT && wait_q == WAIT_MAX) mem_timeout <= 1'b1;
    end
  end

  // One bubble per load-use: the held ID instruction is not stalled twice.
  // A memory freeze keeps the bubble in place, so the block is held too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_block_q <= 1'b0;
    end else if (!(state_q != INIT && mem_wait)) begin
      lu_block_q <= lu_take;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state_q != INIT && !pc_write && stall_cycles != {STALL_W{1'b1}}) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

endmodule
